// File: rtl/drf_port_nibble_tx.sv
// Byte FIFO feeding a two-nibble serializer for the DRF CPU 4-bit port.
// Nibbles are offered under valid/ack; outputs depend only on registered state.
module drf_port_nibble_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [3:0]                    port_data,
    output logic                          port_valid,
    input  logic                          port_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SEND_FIRST  = 2'd1;
    localparam logic [1:0] SEND_SECOND = 2'd2;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    state_reg;
    logic [7:0]    shift_reg;

    logic push;
    logic pop;
    logic fifo_nonempty;

    assign fifo_nonempty = (count_reg != '0);
    assign in_ready      = (count_reg < CW'(FIFO_DEPTH));
    assign push          = in_valid && in_ready;
    // A pop only sees bytes already stored before this edge.
    assign pop = fifo_nonempty &&
                 ((state_reg == IDLE) || ((state_reg == SEND_SECOND) && port_ack));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= 8'h00;
        end else begin
            if (pop) begin
                shift_reg <= mem[rd_ptr_reg];
            end
            case (state_reg)
                IDLE: begin
                    if (pop) state_reg <= SEND_FIRST;
                end
                SEND_FIRST: begin
                    if (port_ack) state_reg <= SEND_SECOND;
                end
                SEND_SECOND: begin
                    if (port_ack) state_reg <= pop ? SEND_FIRST : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic [3:0] first_nibble;
    logic [3:0] second_nibble;

    assign first_nibble  = HIGH_FIRST ? shift_reg[7:4] : shift_reg[3:0];
    assign second_nibble = HIGH_FIRST ? shift_reg[3:0] : shift_reg[7:4];

    always_comb begin
        port_data = 4'h0;
        case (state_reg)
            SEND_FIRST:  port_data = first_nibble;
            SEND_SECOND: port_data = second_nibble;
            default:     port_data = 4'h0;
        endcase
    end

    assign port_valid = (state_reg == SEND_FIRST) || (state_reg == SEND_SECOND);
    assign busy       = port_valid;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_drf_port_nibble_tx.sv
// Self-checking bench for drf_port_nibble_tx: directed scenarios plus a
// randomized run checked against a nibble-queue reference model.
module tb_drf_port_nibble_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] port_data;
    logic       port_valid;
    logic       port_ack = 1'b0;
    logic [2:0] fifo_count;
    logic       busy;

    logic [7:0] in_data_lo = 8'h00;
    logic       in_valid_lo = 1'b0;
    logic       in_ready_lo;
    logic [3:0] port_data_lo;
    logic       port_valid_lo;
    logic       port_ack_lo = 1'b0;
    logic [2:0] fifo_count_lo;
    logic       busy_lo;

    int total = 0;
    int bad = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    drf_port_nibble_tx #(.FIFO_DEPTH(4), .HIGH_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .port_data(port_data), .port_valid(port_valid),
        .port_ack(port_ack), .fifo_count(fifo_count), .busy(busy)
    );

    drf_port_nibble_tx #(.FIFO_DEPTH(4), .HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_lo), .in_valid(in_valid_lo),
        .in_ready(in_ready_lo), .port_data(port_data_lo), .port_valid(port_valid_lo),
        .port_ack(port_ack_lo), .fifo_count(fifo_count_lo), .busy(busy_lo)
    );

    // Reference model: every accepted byte becomes two nibbles (high first);
    // every acknowledged valid nibble must equal the oldest outstanding one.
    always @(posedge clk) begin
        if (rst_n) begin
            if (port_valid && port_ack) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_extra: got nibble %h, required none outstanding", port_data);
                end else begin
                    if (port_data !== exp_q[0]) begin
                        bad++;
                        $display("FAIL scoreboard_order: got %h, required %h", port_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data[7:4]);
                exp_q.push_back(in_data[3:0]);
            end
        end
    end

    always @(negedge rst_n) exp_q.delete();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (port_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1 ||
            busy !== 1'b0 || port_data !== 4'h0) begin
            bad++;
            $display("FAIL reset_state: valid=%b count=%0d ready=%b busy=%b data=%h, required 0 0 1 0 0",
                     port_valid, fifo_count, in_ready, busy, port_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        port_ack = 1'b1;
        in_data = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (port_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_latency: port_valid=%b after push edge, required 0", port_valid);
        end
        tick();
        total++;
        if (port_valid !== 1'b1 || port_data !== 4'hA) begin
            bad++;
            $display("FAIL single_first: valid=%b data=%h, required 1 a", port_valid, port_data);
        end
        tick();
        total++;
        if (port_valid !== 1'b1 || port_data !== 4'h5) begin
            bad++;
            $display("FAIL single_second: valid=%b data=%h, required 1 5", port_valid, port_data);
        end
        tick();
        total++;
        if (port_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_end: valid=%b busy=%b, required 0 0", port_valid, busy);
        end
        port_ack = 1'b0;
    endtask

    task automatic test_stall();
        in_data = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (port_valid !== 1'b1 || port_data !== 4'h3) begin
                bad++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h, required 1 3", i, port_valid, port_data);
            end
            tick();
        end
        port_ack = 1'b1;
        tick();
        port_ack = 1'b0;
        total++;
        if (port_valid !== 1'b1 || port_data !== 4'hC) begin
            bad++;
            $display("FAIL stall_second: valid=%b data=%h, required 1 c", port_valid, port_data);
        end
        port_ack = 1'b1;
        tick();
        port_ack = 1'b0;
        total++;
        if (port_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_end: valid=%b, required 0", port_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h12;
        bytes[1] = 8'h34;
        bytes[2] = 8'h56;
        port_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 3);
            in_data = (k < 3) ? bytes[k] : 8'h00;
            tick();
            total++;
            if (k == 0 || k == 7) begin
                if (port_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle[%0d]: valid=%b, required 0", k, port_valid);
                end
            end else if (port_valid !== 1'b1 || port_data !== 4'(k)) begin
                bad++;
                $display("FAIL b2b_stream[%0d]: valid=%b data=%h, required 1 %h", k, port_valid, port_data, 4'(k));
            end
        end
        in_valid = 1'b0;
        total++;
        if (fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL b2b_count: fifo_count=%0d, required 0", fifo_count);
        end
        port_ack = 1'b0;
    endtask

    task automatic test_full();
        logic [7:0] bytes [5];
        port_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom);
            in_data = bytes[i];
            in_valid = 1'b1;
            tick();
        end
        total++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_state: count=%0d ready=%b, required 4 0", fifo_count, in_ready);
        end
        in_data = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL full_reject[%0d]: count=%0d ready=%b, required 4 0", i, fifo_count, in_ready);
            end
        end
        in_valid = 1'b0;
        port_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] want;
            want = (i % 2 == 0) ? bytes[i / 2][7:4] : bytes[i / 2][3:0];
            total++;
            if (port_valid !== 1'b1 || port_data !== want) begin
                bad++;
                $display("FAIL full_drain[%0d]: valid=%b data=%h, required 1 %h", i, port_valid, port_data, want);
            end
            tick();
        end
        total++;
        if (port_valid !== 1'b0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL full_end: valid=%b count=%0d, required 0 0", port_valid, fifo_count);
        end
        port_ack = 1'b0;
    endtask

    task automatic test_low_first();
        port_ack_lo = 1'b1;
        in_data_lo = 8'hF0;
        in_valid_lo = 1'b1;
        tick();
        in_valid_lo = 1'b0;
        tick();
        total++;
        if (port_valid_lo !== 1'b1 || port_data_lo !== 4'h0) begin
            bad++;
            $display("FAIL low_first: valid=%b data=%h, required 1 0", port_valid_lo, port_data_lo);
        end
        tick();
        total++;
        if (port_valid_lo !== 1'b1 || port_data_lo !== 4'hF) begin
            bad++;
            $display("FAIL low_second: valid=%b data=%h, required 1 f", port_valid_lo, port_data_lo);
        end
        tick();
        total++;
        if (port_valid_lo !== 1'b0) begin
            bad++;
            $display("FAIL low_end: valid=%b, required 0", port_valid_lo);
        end
        port_ack_lo = 1'b0;
    endtask

    task automatic test_random();
        int outstanding;
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 99) < 55);
            in_data = 8'($urandom);
            port_ack = ($urandom_range(0, 99) < 60);
            tick();
            outstanding = (exp_q.size() + 1) / 2;
            total++;
            if (int'(fifo_count) + int'(busy) != outstanding || fifo_count > 3'd4) begin
                bad++;
                $display("FAIL random_occupancy[%0d]: count=%0d busy=%b, required %0d bytes outstanding",
                         c, fifo_count, busy, outstanding);
            end
        end
        in_valid = 1'b0;
        port_ack = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        total++;
        if (exp_q.size() != 0 || port_valid !== 1'b0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL random_drain: left=%0d valid=%b count=%0d, required 0 0 0",
                     exp_q.size(), port_valid, fifo_count);
        end
        port_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        port_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h40 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        port_ack = 1'b1;
        tick();
        port_ack = 1'b0;
        total++;
        if (fifo_count !== 3'd3 || port_data !== 4'h0 || port_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup: count=%0d data=%h valid=%b, required 3 0 1", fifo_count, port_data, port_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (port_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: valid=%b count=%0d ready=%b busy=%b, required 0 0 1 0",
                     port_valid, fifo_count, in_ready, busy);
        end
        tick();
        rst_n = 1'b1;
        port_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (port_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_quiet[%0d]: valid=%b, required 0", i, port_valid);
            end
        end
        port_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_full();
        test_low_first();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drf_port_nibble_tx.md
Name: drf_port_nibble_tx

Overview:
- Device-side transmitter that feeds the DRF CPU's 4-bit `port_input` bus.
- Accepts 8-bit bytes from a producer (host bench, UART bridge, ROM loader) into a small byte FIFO.
- Serializes each byte into two 4-bit nibbles, offered one at a time under a valid/ack handshake.
- Counterpart of the CPU's nibble-wide port: the CPU (or its port glue) consumes nibbles and rebuilds bytes for the register file.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; must be a power of two, 2..16.
- HIGH_FIRST, 1, 1 = send bits [7:4] first then [3:0]; 0 = low nibble first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  byte to enqueue.
- in_valid  input  1  producer has a byte on in_data.
- in_ready  output  1  FIFO can accept a byte this cycle.
- port_data  output  4  nibble offered to the CPU port.
- port_valid  output  1  port_data holds a valid nibble.
- port_ack  input  1  consumer takes the current nibble on this rising edge.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes stored in the FIFO; excludes the byte held in the serializer.
- busy  output  1  high while the serializer holds a byte (state != IDLE).

Behaviour:
- Reset: asynchronous, active-low; clk and rst_n named as above; single clock domain.
- Reset values: FIFO empty, fifo_count=0, in_ready=1, port_valid=0, port_data=4'h0, busy=0, state=IDLE.
- Reset mid-operation: the in-flight byte and all queued bytes are discarded; no partial nibble is emitted after release.
- Push: occurs on an edge where in_valid && in_ready; in_data is written at the write pointer.
- in_ready: combinational, equals (fifo_count < FIFO_DEPTH).
- Full FIFO: in_ready=0 even if a pop happens the same cycle; no push-through when full.
- Pointers: wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SEND_FIRST, SEND_SECOND.
- IDLE:
  - If fifo_count>0: pop head into shift_byte and go to SEND_FIRST.
  - Else stay in IDLE.
- SEND_FIRST:
  - port_valid=1; port_data = first nibble (per HIGH_FIRST).
  - On port_ack, go to SEND_SECOND.
  - Otherwise hold port_data stable.
- SEND_SECOND:
  - port_valid=1; port_data = second nibble.
  - On port_ack with fifo_count>0: pop next byte in the same edge and go to SEND_FIRST. Back-to-back; port_valid stays high.
  - On port_ack with FIFO empty: go to IDLE; port_valid=0 next cycle.
- Outputs: port_data, port_valid and busy are registered, derived from the state register and shift_byte; no combinational path from port_ack.
- Latency: byte pushed at edge N into an empty FIFO with FSM in IDLE → popped at edge N+1 → port_valid=1 after edge N+1.
- Simultaneous push and pop on one edge (FIFO not full): fifo_count is unchanged; both pointers advance.
- Push into an empty FIFO on the same edge the FSM checks it: not visible to the pop that edge; popped on the next edge.
- port_ack while port_valid=0: ignored, no state change.
- Throughput: one nibble per cycle when port_ack is held high; one byte per 2 cycles sustained.
- Ordering: strict FIFO order; nibble order fixed by HIGH_FIRST.
- No data loss or duplication under any ack pattern.
- fifo_count never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Reset check: assert rst_n=0 mid-simulation with 3 bytes queued and FSM in SEND_SECOND → immediately port_valid=0, fifo_count=0, in_ready=1, busy=0; after release with no pushes, port_valid stays 0 for 10 cycles.
- Single byte, HIGH_FIRST=1: push 8'hA5 at edge N, port_ack held 1 → port_data=4'hA valid after N+1, 4'h5 after N+2, port_valid=0 after N+3.
- Stall: push 8'h3C, hold port_ack=0 for 5 cycles → port_data stays 4'h3 with port_valid=1 throughout; ack once → 4'hC presented next cycle.
- Back-to-back: push 8'h12, 8'h34, 8'h56 on consecutive edges, port_ack=1 → nibble stream 1,2,3,4,5,6 on 6 consecutive cycles with no valid gap; fifo_count returns to 0.
- Full FIFO (FIFO_DEPTH=4), port_ack=0: push 5 bytes → first enters the serializer; next 4 fill the FIFO (fifo_count=4, in_ready=0); a 6th offered byte is not accepted; release ack → all 5 bytes emerge in order.
- HIGH_FIRST=0: push 8'hF0 → nibble 4'h0 then 4'hF.
